// File: rtl/pma_pkg.sv
// rtl/pma_pkg.sv - shared types and constants for the PMA region checker
package pma_pkg;

    localparam int unsigned AttrCachedBit  = 0;
    localparam int unsigned AttrNonIdemBit = 1;
    localparam int unsigned AttrExecBit    = 2;
    localparam int unsigned AttrCapTagBit  = 3;

    localparam int unsigned PmaAddrWidth = 64;

    // Member order puts cached at bit 0 to match the attribute bus layout.
    typedef struct packed {
        logic cap_tag_ok;
        logic executable;
        logic non_idempotent;
        logic cached;
    } pma_attr_t;

    typedef struct packed {
        logic [PmaAddrWidth-1:0] base;
        logic [PmaAddrWidth-1:0] len;
        pma_attr_t               attr;
        logic                    lock;
    } pma_rule_t;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        COMMIT = 2'd1,
        RESP   = 2'd2
    } cfg_state_e;

endpackage

// File: rtl/pma_rule_match.sv
// rtl/pma_rule_match.sv - combinational lowest-index-wins region match for one address
module pma_rule_match #(
    parameter int unsigned         NrRules     = 8,
    parameter int unsigned         AddrWidth   = 64,
    parameter int unsigned         NrAttr      = 4,
    parameter int unsigned         IdxW        = 3,
    parameter logic [NrAttr-1:0]   DefaultAttr = '0
) (
    input  logic [AddrWidth-1:0]               addr_i,
    input  logic [NrRules-1:0][AddrWidth-1:0]  base_i,
    input  logic [NrRules-1:0][AddrWidth-1:0]  len_i,
    input  logic [NrRules-1:0][NrAttr-1:0]     attr_i,
    output logic                               hit_o,
    output logic [IdxW-1:0]                    idx_o,
    output logic [NrAttr-1:0]                  attr_o
);

    logic [NrRules-1:0] match;

    // Upper bound carries one extra bit so a region ending at the top of memory does not wrap.
    for (genvar r = 0; r < NrRules; r++) begin : g_cmp
        assign match[r] = (len_i[r] != '0) &&
                          (addr_i >= base_i[r]) &&
                          ({1'b0, addr_i} < ({1'b0, base_i[r]} + {1'b0, len_i[r]}));
    end

    always_comb begin
        hit_o  = 1'b0;
        idx_o  = '0;
        attr_o = DefaultAttr;
        for (int r = NrRules - 1; r >= 0; r--) begin
            if (match[r]) begin
                hit_o  = 1'b1;
                idx_o  = IdxW'(r);
                attr_o = attr_i[r];
            end
        end
    end

endmodule

// File: rtl/pma_region_checker.sv
// rtl/pma_region_checker.sv - runtime-programmable PMA table with lockable rules and multi-channel lookup
module pma_region_checker
    import pma_pkg::*;
#(
    parameter int unsigned NrRules    = 8,
    parameter int unsigned NrChannels = 2,
    parameter int unsigned AddrWidth  = 64,
    parameter int unsigned NrAttr     = 4,
    parameter int unsigned IdxW       = (NrRules > 1) ? $clog2(NrRules) : 1,
    parameter logic [NrRules-1:0][AddrWidth-1:0] RstBase     = '0,
    parameter logic [NrRules-1:0][AddrWidth-1:0] RstLength   = '0,
    parameter logic [NrRules-1:0][NrAttr-1:0]    RstAttr     = '0,
    parameter logic [NrAttr-1:0]                 DefaultAttr = '0
) (
    input  logic                                  clk_i,
    input  logic                                  rst_i,
    input  logic                                  cfg_valid_i,
    output logic                                  cfg_ready_o,
    input  logic [IdxW-1:0]                       cfg_idx_i,
    input  logic [AddrWidth-1:0]                  cfg_base_i,
    input  logic [AddrWidth-1:0]                  cfg_len_i,
    input  logic [NrAttr-1:0]                     cfg_attr_i,
    input  logic                                  cfg_lock_i,
    output logic                                  cfg_done_o,
    output logic                                  cfg_err_o,
    input  logic [NrChannels-1:0]                 lkp_valid_i,
    input  logic [NrChannels-1:0][AddrWidth-1:0]  lkp_addr_i,
    output logic [NrChannels-1:0]                 rsp_valid_o,
    output logic [NrChannels-1:0]                 rsp_hit_o,
    output logic [NrChannels-1:0][IdxW-1:0]       rsp_idx_o,
    output logic [NrChannels-1:0][NrAttr-1:0]     rsp_attr_o
);

    logic [NrRules-1:0][AddrWidth-1:0] base_q, base_d;
    logic [NrRules-1:0][AddrWidth-1:0] len_q, len_d;
    logic [NrRules-1:0][NrAttr-1:0]    attr_q, attr_d;
    logic [NrRules-1:0]                lock_q, lock_d;

    cfg_state_e           state_q, state_d;
    logic [IdxW-1:0]      req_idx_q, req_idx_d;
    logic [AddrWidth-1:0] req_base_q, req_base_d;
    logic [AddrWidth-1:0] req_len_q, req_len_d;
    logic [NrAttr-1:0]    req_attr_q, req_attr_d;
    logic                 req_lock_q, req_lock_d;
    logic                 err_q, err_d;

    logic [NrChannels-1:0]               rsp_valid_q, rsp_valid_d;
    logic [NrChannels-1:0]               rsp_hit_q, rsp_hit_d;
    logic [NrChannels-1:0][IdxW-1:0]     rsp_idx_q, rsp_idx_d;
    logic [NrChannels-1:0][NrAttr-1:0]   rsp_attr_q, rsp_attr_d;

    logic [NrChannels-1:0]               match_hit;
    logic [NrChannels-1:0][IdxW-1:0]     match_idx;
    logic [NrChannels-1:0][NrAttr-1:0]   match_attr;

    // The whole entry is written on one edge at the end of COMMIT, so lookups never see a torn rule.
    always_comb begin
        state_d    = state_q;
        req_idx_d  = req_idx_q;
        req_base_d = req_base_q;
        req_len_d  = req_len_q;
        req_attr_d = req_attr_q;
        req_lock_d = req_lock_q;
        err_d      = err_q;
        base_d     = base_q;
        len_d      = len_q;
        attr_d     = attr_q;
        lock_d     = lock_q;
        case (state_q)
            IDLE: begin
                if (cfg_valid_i) begin
                    req_idx_d  = cfg_idx_i;
                    req_base_d = cfg_base_i;
                    req_len_d  = cfg_len_i;
                    req_attr_d = cfg_attr_i;
                    req_lock_d = cfg_lock_i;
                    state_d    = COMMIT;
                end
            end
            COMMIT: begin
                err_d = 1'b1;
                for (int r = 0; r < NrRules; r++) begin
                    if (req_idx_q == IdxW'(r) && !lock_q[r]) begin
                        base_d[r] = req_base_q;
                        len_d[r]  = req_len_q;
                        attr_d[r] = req_attr_q;
                        lock_d[r] = req_lock_q;
                        err_d     = 1'b0;
                    end
                end
                state_d = RESP;
            end
            RESP:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    for (genvar c = 0; c < NrChannels; c++) begin : g_chan
        pma_rule_match #(
            .NrRules     (NrRules),
            .AddrWidth   (AddrWidth),
            .NrAttr      (NrAttr),
            .IdxW        (IdxW),
            .DefaultAttr (DefaultAttr)
        ) u_match (
            .addr_i (lkp_addr_i[c]),
            .base_i (base_q),
            .len_i  (len_q),
            .attr_i (attr_q),
            .hit_o  (match_hit[c]),
            .idx_o  (match_idx[c]),
            .attr_o (match_attr[c])
        );
    end

    always_comb begin
        rsp_valid_d = lkp_valid_i;
        rsp_hit_d   = rsp_hit_q;
        rsp_idx_d   = rsp_idx_q;
        rsp_attr_d  = rsp_attr_q;
        for (int c = 0; c < NrChannels; c++) begin
            if (lkp_valid_i[c]) begin
                rsp_hit_d[c]  = match_hit[c];
                rsp_idx_d[c]  = match_idx[c];
                rsp_attr_d[c] = match_attr[c];
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            base_q      <= RstBase;
            len_q       <= RstLength;
            attr_q      <= RstAttr;
            lock_q      <= '0;
            state_q     <= IDLE;
            req_idx_q   <= '0;
            req_base_q  <= '0;
            req_len_q   <= '0;
            req_attr_q  <= '0;
            req_lock_q  <= 1'b0;
            err_q       <= 1'b0;
            rsp_valid_q <= '0;
            rsp_hit_q   <= '0;
            rsp_idx_q   <= '0;
            rsp_attr_q  <= '0;
        end else begin
            base_q      <= base_d;
            len_q       <= len_d;
            attr_q      <= attr_d;
            lock_q      <= lock_d;
            state_q     <= state_d;
            req_idx_q   <= req_idx_d;
            req_base_q  <= req_base_d;
            req_len_q   <= req_len_d;
            req_attr_q  <= req_attr_d;
            req_lock_q  <= req_lock_d;
            err_q       <= err_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_hit_q   <= rsp_hit_d;
            rsp_idx_q   <= rsp_idx_d;
            rsp_attr_q  <= rsp_attr_d;
        end
    end

    assign cfg_ready_o = (state_q == IDLE);
    assign cfg_done_o  = (state_q == RESP);
    assign cfg_err_o   = (state_q == RESP) && err_q;
    assign rsp_valid_o = rsp_valid_q;
    assign rsp_hit_o   = rsp_hit_q;
    assign rsp_idx_o   = rsp_idx_q;
    assign rsp_attr_o  = rsp_attr_q;

endmodule
